// File: rtl/conv3x3_mac_pipe.sv
// 3x3 multi-channel convolution MAC with bias, shift, ReLU and saturation.
// Three-stage pipeline, one window per cycle, plus frame position counters.
module conv3x3_mac_pipe #(
  parameter int DATAW  = 8,
  parameter int IFM_CH = 8,
  parameter int OFM_CH = 4,
  parameter int ACCW   = 32
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      win_vld,
  input  logic [DATAW*IFM_CH*9-1:0] win_data,
  input  logic                      wgt_wr_en,
  input  logic [3:0]                wgt_wr_addr,
  input  logic [DATAW*IFM_CH*9-1:0] wgt_wr_data,
  input  logic [ACCW-1:0]           wgt_wr_bias,
  input  logic [4:0]                cfg_shift,
  input  logic                      cfg_relu,
  input  logic [15:0]               cfg_out_w,
  input  logic [15:0]               cfg_out_h,
  output logic                      out_vld,
  output logic [DATAW*OFM_CH-1:0]   out_data,
  output logic                      frame_done
);
  localparam int N    = 9 * IFM_CH;
  localparam int WINW = DATAW * N;
  localparam int PW   = 2 * DATAW;

  localparam logic signed [ACCW:0] SMAX =
    {{(ACCW-DATAW+2){1'b0}}, {(DATAW-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN =
    {{(ACCW-DATAW+2){1'b1}}, {(DATAW-1){1'b0}}};

  logic [WINW-1:0]        kern   [OFM_CH];
  logic signed [ACCW-1:0] bias   [OFM_CH];
  logic signed [PW-1:0]   prod_d [OFM_CH][N];
  logic signed [PW-1:0]   prod_q [OFM_CH][N];
  logic signed [ACCW-1:0] bias1  [OFM_CH];
  logic signed [ACCW-1:0] bias2  [OFM_CH];
  logic signed [ACCW-1:0] sum_d  [OFM_CH];
  logic signed [ACCW-1:0] sum_q  [OFM_CH];
  logic [DATAW*OFM_CH-1:0] res_d;
  logic v1, v2;
  logic [15:0] out_col, out_row;
  logic frame_zero, last_col, last_row;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int o = 0; o < OFM_CH; o++) begin
        kern[o] <= '0;
        bias[o] <= '0;
      end
    end else if (wgt_wr_en) begin
      for (int o = 0; o < OFM_CH; o++) begin
        if (wgt_wr_addr == 4'(o)) begin
          kern[o] <= wgt_wr_data;
          bias[o] <= wgt_wr_bias;
        end
      end
    end
  end

  // Operands widen to the product width before multiplying.
  always_comb begin
    logic signed [PW-1:0] a, b;
    a = '0;
    b = '0;
    for (int o = 0; o < OFM_CH; o++) begin
      for (int j = 0; j < N; j++) begin
        a = PW'($signed(win_data[j*DATAW +: DATAW]));
        b = PW'($signed(kern[o][j*DATAW +: DATAW]));
        prod_d[o][j] = a * b;
      end
    end
  end

  always_comb begin
    logic signed [ACCW-1:0] s;
    s = '0;
    for (int o = 0; o < OFM_CH; o++) begin
      s = '0;
      for (int j = 0; j < N; j++)
        s = s + ACCW'(prod_q[o][j]);
      sum_d[o] = s;
    end
  end

  // One extra bit keeps the bias add from wrapping before saturation.
  always_comb begin
    logic signed [ACCW:0] t;
    logic signed [ACCW:0] sh;
    t = '0;
    sh = '0;
    res_d = '0;
    for (int o = 0; o < OFM_CH; o++) begin
      t = $signed({bias2[o][ACCW-1], bias2[o]})
        + $signed({sum_q[o][ACCW-1], sum_q[o]});
      sh = t >>> cfg_shift;
      if (cfg_relu && sh < 0)
        sh = '0;
      if (sh > SMAX)
        res_d[o*DATAW +: DATAW] = SMAX[DATAW-1:0];
      else if (sh < SMIN)
        res_d[o*DATAW +: DATAW] = SMIN[DATAW-1:0];
      else
        res_d[o*DATAW +: DATAW] = sh[DATAW-1:0];
    end
  end

  // Bias travels with its window so a mid-flight write cannot split it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      for (int o = 0; o < OFM_CH; o++) begin
        bias1[o] <= '0;
        bias2[o] <= '0;
        sum_q[o] <= '0;
        for (int j = 0; j < N; j++)
          prod_q[o][j] <= '0;
      end
    end else begin
      v1      <= win_vld;
      v2      <= v1;
      out_vld <= v2;
      for (int o = 0; o < OFM_CH; o++) begin
        bias1[o] <= bias[o];
        bias2[o] <= bias1[o];
        sum_q[o] <= sum_d[o];
        for (int j = 0; j < N; j++)
          prod_q[o][j] <= prod_d[o][j];
      end
      if (v2)
        out_data <= res_d;
    end
  end

  assign frame_zero = (cfg_out_w == 16'd0) || (cfg_out_h == 16'd0);
  assign last_col   = out_col >= cfg_out_w - 16'd1;
  assign last_row   = out_row >= cfg_out_h - 16'd1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_zero) begin
        out_col <= '0;
        out_row <= '0;
      end else if (v2) begin
        if (last_col) begin
          out_col <= '0;
          if (last_row) begin
            out_row    <= '0;
            frame_done <= 1'b1;
          end else begin
            out_row <= out_row + 16'd1;
          end
        end else begin
          out_col <= out_col + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/conv3x3_mac_pipe.md
CONV3X3_MAC_PIPE -- requirements
Module: conv3x3_mac_pipe

Interface
REQ-001 SHALL have parameter DATAW, default 8, meaning bits per signed channel sample and per weight.
REQ-002 SHALL have parameter IFM_CH, default 8, meaning input channels per window tap.
REQ-003 SHALL have parameter OFM_CH, default 4, meaning output channels computed in parallel.
REQ-004 SHALL have parameter ACCW, default 32, meaning accumulator and bias width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port win_vld, input, 1 bit: a 3x3 window is present on win_data this cycle.
REQ-008 SHALL have port win_data, input, DATAW*IFM_CH*9 bits: tap k (0..8, top-left to bottom-right, top = oldest row) at bits [(9-k)*DATAW*IFM_CH-1 -: DATAW*IFM_CH]; channel c of a tap at [c*DATAW +: DATAW].
REQ-009 SHALL have port wgt_wr_en, input, 1 bit: weight/bias write strobe.
REQ-010 SHALL have port wgt_wr_addr, input, 4 bits: output channel being written.
REQ-011 SHALL have port wgt_wr_data, input, DATAW*IFM_CH*9 bits: kernel for that output channel, same layout as win_data.
REQ-012 SHALL have port wgt_wr_bias, input, ACCW bits: signed bias for that output channel.
REQ-013 SHALL have port cfg_shift, input, 5 bits: arithmetic right shift applied to biased sum.
REQ-014 SHALL have port cfg_relu, input, 1 bit: clamp negative results to 0.
REQ-015 SHALL have ports cfg_out_w and cfg_out_h, input, 16 bits each: output frame width and height in windows.
REQ-016 SHALL have port out_vld, output, 1 bit: out_data holds a result.
REQ-017 SHALL have port out_data, output, DATAW*OFM_CH bits: output channel o at [o*DATAW +: DATAW], signed.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse with the last result of a frame.

Function
REQ-019 SHALL hold OFM_CH kernel and bias registers; wgt_wr_en with wgt_wr_addr < OFM_CH writes that entry at the clock edge; addr >= OFM_CH ignored.
REQ-020 SHALL treat all samples, weights and biases as two's complement.
REQ-021 SHALL use a 3-stage pipeline, no backpressure, one window per cycle: S1 registers 9*IFM_CH signed products per output channel (2*DATAW bits); S2 registers sign-extended sum of products in ACCW bits; S3 adds bias, shifts right arithmetically by cfg_shift, applies ReLU if cfg_relu, saturates to [-2^(DATAW-1), 2^(DATAW-1)-1], registers to out_data.
REQ-022 SHALL assert out_vld exactly 3 cycles after the edge sampling win_vld=1; out_vld=0 otherwise; out_data holds last value when out_vld=0.
REQ-023 SHALL make a window sampled in the same cycle as a weight write use the old weights; the next window uses the new weights.
REQ-024 SHALL sample cfg_shift and cfg_relu at S3 (value present when the result is registered).
REQ-025 SHALL keep out_col/out_row counters advancing on each out_vld: out_col wraps at cfg_out_w-1 and increments out_row; frame_done pulses with out_vld when out_col==cfg_out_w-1 and out_row==cfg_out_h-1, both counters then return to 0.
REQ-026 SHALL hold counters at 0 and never pulse frame_done while cfg_out_w or cfg_out_h is 0.
REQ-027 SHALL compute all products and sums without overflow for DATAW=8, IFM_CH=8, ACCW=32.

Reset
REQ-028 SHALL on rst_b=0 immediately clear out_vld, frame_done, out_data, all stage valids, counters, kernels and biases to 0.
REQ-029 SHALL discard all in-flight windows on reset mid-operation; no out_vld until 3 cycles after a window sampled after rst_b rises.

Verification
REQ-030 SHALL cover: all samples 1, all weights 1, bias 0, shift 0, relu 0, one window -> out_vld 3 cycles later, every channel 72 (0x48).
REQ-031 SHALL cover: samples 127, weights 127 -> every channel 127; samples 1, weights -1 -> -72 (0xB8) with relu 0, 0x00 with relu 1.
REQ-032 SHALL cover: sum 72, bias 8, shift 3 -> 10; bias -80, shift 0, relu 0 -> -8 (0xF8).
REQ-033 SHALL cover: cfg_out_w=4, cfg_out_h=2, 8 back-to-back windows -> 8 consecutive out_vld, frame_done only on 8th, counters 0 after.
REQ-034 SHALL cover: weight write to ch0 in the same cycle as window A, window B next cycle -> A uses old, B uses new kernel; write to addr 5 changes nothing.
REQ-035 SHALL cover: rst_b low one cycle after 2 windows enter -> no out_vld from them, all outputs 0, kernels 0.
